// File: rtl/fpga_top_pkg.sv
// Shared widths for the LED/button bring-up top.
// FPGA_TOP_HEARTBEAT_EN narrows the press counter to make room for the heartbeat LED.
package fpga_top_pkg;
    localparam int LED_W    = 16;
`ifdef FPGA_TOP_HEARTBEAT_EN
    localparam int CNT_W    = 14;
`else
    localparam int CNT_W    = 15;
`endif
    localparam int DB_CNT_W = 24;
endpackage

// File: rtl/fpga_top_btn_debounce.sv
// Two-flop synchronizer plus stable-level debouncer for one push-button.
module btn_debounce
    import fpga_top_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic btn_db
);
    localparam logic [DB_CNT_W-1:0] LIMIT = DB_CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]          sync;
    logic [DB_CNT_W-1:0] cnt;
    logic [DB_CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + DB_CNT_W'(1);

    // sync[1] is the CLK-domain button; the counter tracks how long it has disagreed with btn_db
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync   <= '0;
            cnt    <= '0;
            btn_db <= 1'b0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (sync[1] == btn_db) begin
                cnt <= '0;
            end else if (cnt_nxt == LIMIT) begin
                btn_db <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end
endmodule

// File: rtl/fpga_top.sv
// Board top: debounced button on LED[15], press count on the lower LEDs.
// FPGA_TOP_HEARTBEAT_EN adds a heartbeat on LED[14] and a 14-bit counter.
module fpga_top
    import fpga_top_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HEARTBEAT_DIV   = 50000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_CTRL,
    output logic [LED_W-1:0] LED
);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 24'hFFFFFF || HEARTBEAT_DIV < 1) begin : g_bad_param
        $error("fpga_top: DEBOUNCE_CYCLES or HEARTBEAT_DIV out of range");
    end

    logic             btn_db;
    logic             db_q;
    logic             press;
    logic [CNT_W-1:0] press_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .CLK    (CLK),
        .RST    (RST),
        .btn_raw(BTN_CTRL),
        .btn_db (btn_db)
    );

    assign press = btn_db & ~db_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            db_q      <= 1'b0;
            press_cnt <= '0;
        end else begin
            db_q <= btn_db;
            if (press) press_cnt <= press_cnt + CNT_W'(1);
        end
    end

`ifdef FPGA_TOP_HEARTBEAT_EN
    localparam logic [31:0] HB_LAST = 32'(HEARTBEAT_DIV - 1);

    logic [31:0] hb_cnt;
    logic        hb;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end

    assign LED = {btn_db, hb, press_cnt};
`else
    assign LED = {btn_db, press_cnt};
`endif
endmodule

// File: tb/tb_fpga_top.sv
// Directed scoreboard bench for fpga_top: reset, press/release latency, glitch, reset mid-debounce, wrap.
module tb_fpga_top;
    import fpga_top_pkg::*;

`ifdef FPGA_TOP_HEARTBEAT_EN
    localparam logic [15:0] MASK = 16'hBFFF;
`else
    localparam logic [15:0] MASK = 16'hFFFF;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        CLK = 1'b0;
    logic        RST, BTN_CTRL, rst2, btn2;
    logic [15:0] LED, led2;

    fpga_top #(.DEBOUNCE_CYCLES(4), .HEARTBEAT_DIV(8)) dut (
        .CLK(CLK), .RST(RST), .BTN_CTRL(BTN_CTRL), .LED(LED)
    );
    fpga_top #(.DEBOUNCE_CYCLES(1), .HEARTBEAT_DIV(8)) dut_fast (
        .CLK(CLK), .RST(rst2), .BTN_CTRL(btn2), .LED(led2)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          fast;
        logic [15:0] led;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] obs;
    int          total = 0;
    int          bad   = 0;
    int          cnt   = 0;

    function automatic logic [15:0] led_of(bit lvl, int c);
        return {lvl, 15'(c)};
    endfunction

    task automatic push(int dc, bit fast, bit lvl, int c, string tag);
        exp_t x;
        x.cyc  = cyc + dc;
        x.fast = fast;
        x.led  = led_of(lvl, c);
        x.tag  = tag;
        sb.push_back(x);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            obs = e.fast ? led2 : LED;
            total++;
            assert ((obs & MASK) === (e.led & MASK))
            else begin
                bad++;
                $error("FAIL %s: LED=%h expected %h at cycle %0d", e.tag, obs, e.led, cyc);
            end
        end
    end

    task automatic press_release();
        BTN_CTRL = 1'b1;
        push(5, 0, 0, cnt,     "press_pre");
        push(6, 0, 1, cnt,     "press_db");
        push(7, 0, 1, cnt + 1, "press_cnt");
        cnt++;
        tick(10);
        BTN_CTRL = 1'b0;
        push(5, 0, 1, cnt, "rel_pre");
        push(6, 0, 0, cnt, "rel_db");
        tick(10);
    endtask

    initial begin
        RST = 1'b1; BTN_CTRL = 1'b1; rst2 = 1'b1; btn2 = 1'b0;
        for (int i = 1; i <= 3; i++) push(i, 0, 0, 0, "rst_hold");
        push(3, 1, 0, 0, "rst_fast");
        tick(3);

        // button held through reset release: counted once after full latency
        RST = 1'b0; rst2 = 1'b0;
        push(5, 0, 0, 0, "rst_rel_c5");
        push(6, 0, 1, 0, "rst_rel_c6");
        push(7, 0, 1, 1, "rst_rel_c7");
        cnt = 1;
        tick(9);
        BTN_CTRL = 1'b0;
        push(5, 0, 1, 1, "rst_rel_hold");
        push(6, 0, 0, 1, "rst_rel_fall");
        tick(10);

        press_release();
        press_release();

        // 3-sample glitch must not move btn_db or the count
        BTN_CTRL = 1'b1;
        push(6,  0, 0, cnt, "glitch_a");
        push(9,  0, 0, cnt, "glitch_b");
        push(14, 0, 0, cnt, "glitch_c");
        tick(3);
        BTN_CTRL = 1'b0;
        tick(14);

        // reset two cycles into a press discards it; it re-qualifies afterwards
        BTN_CTRL = 1'b1;
        push(3,  0, 0, 0, "mid_rst");
        push(9,  0, 0, 0, "mid_requal");
        push(10, 0, 1, 0, "mid_db");
        push(11, 0, 1, 1, "mid_cnt");
        tick(2);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        cnt = 1;
        tick(12);
        BTN_CTRL = 1'b0;
        push(6, 0, 0, cnt, "mid_rel");
        tick(10);

        // wrap-around on the single-sample debounce instance
        for (int i = 0; i < CNT_MAX; i++) begin
            btn2 = 1'b1; tick(1);
            btn2 = 1'b0; tick(1);
        end
        tick(6);
        push(1, 1, 0, CNT_MAX, "wrap_full");
        tick(1);
        btn2 = 1'b1;
        push(3, 1, 1, CNT_MAX, "wrap_db");
        push(4, 1, 1, 0,       "wrap_zero");
        tick(6);
        btn2 = 1'b0;
        push(3, 1, 0, 0, "wrap_rel");
        tick(6);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        total++;
        assert (sb.size() == 0)
        else begin
            bad++;
            $error("FAIL sb_drain: pending=%0d expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
